// File: rtl/vpu_pkg.sv
// Shared types and constants for the VPU bias scheduler.
package vpu_pkg;

    // Bias-path sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } vpu_sched_state_e;

    // Bit of the VPU mode word that enables the bias add (0 = bypass, zero bias).
    localparam int VPU_MODE_BIAS_EN_BIT = 0;

    // Cycles between a bias buffer read strobe and its row data.
    localparam int BIAS_RD_LATENCY = 1;

endpackage

// File: rtl/vpu_skew_line.sv
// Registered data+valid delay line; one instance per lane sets that lane's skew.
module vpu_skew_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  any_valid_o
);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    // Shift data and valid one stage per cycle; stage 0 captures the input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    assign data_o      = data_q[DEPTH-1];
    assign valid_o     = valid_q[DEPTH-1];
    // Any token still in flight anywhere in the line (used to hold off completion).
    assign any_valid_o = |valid_q;

endmodule

// File: rtl/vpu_bias_sched.sv
// Bias (C-matrix) sequencer for one D = E + C tile: reads one bias row per
// cycle, skews it across lanes to meet the systolic psums, counts completed
// output rows and flags psums that arrive without bias.
module vpu_bias_sched
    import vpu_pkg::*;
#(
    parameter int VPU_WIDTH  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ROWS_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [ADDR_WIDTH-1:0]           cmd_base_addr,
    input  logic [ROWS_WIDTH-1:0]           cmd_rows,
    input  logic [ROWS_WIDTH-1:0]           cmd_start_delay,
    input  logic [2:0]                      cmd_mode,
    output logic                            bias_rd_en,
    output logic [ADDR_WIDTH-1:0]           bias_rd_addr,
    input  logic [DATA_WIDTH*VPU_WIDTH-1:0] bias_rd_data,
    output logic [2:0]                      vpu_mode,
    output logic [DATA_WIDTH*VPU_WIDTH-1:0] vpu_bias_data_out,
    output logic [VPU_WIDTH-1:0]            vpu_bias_valid_out,
    input  logic [VPU_WIDTH-1:0]            vpu_sys_valid_in,
    input  logic                            vpu_valid_in,
    output logic                            busy,
    output logic                            done,
    output logic                            err_misalign
);

    vpu_sched_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [ROWS_WIDTH-1:0]  rows_q, rows_d;
    logic [ROWS_WIDTH-1:0]  delay_q, delay_d;
    logic [ROWS_WIDTH-1:0]  issue_q, issue_d;
    logic [ROWS_WIDTH-1:0]  comp_q, comp_d;
    logic [2:0]             mode_q, mode_d;
    logic                   err_q, err_d;
    logic [BIAS_RD_LATENCY-1:0] tok_q;

    logic                   cmd_ready_q, busy_q, done_q, rd_en_q;
    logic [ADDR_WIDTH-1:0]  rd_addr_q;
    logic [2:0]             vpu_mode_q;

    logic                   accept_s;
    logic                   issue_s;
    logic                   tok_s;
    logic                   bias_en_s;
    logic [VPU_WIDTH-1:0]   lane_busy_s;
    logic                   pipe_busy_s;

    assign issue_s     = (state_q == ISSUE);
    // Row token emerges alongside the buffer data it stands for.
    assign tok_s       = tok_q[BIAS_RD_LATENCY-1];
    assign bias_en_s   = mode_q[VPU_MODE_BIAS_EN_BIT];
    assign pipe_busy_s = (|tok_q) | (|lane_busy_s);

    // Next-state, command latching, completion counting and misalignment detection.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        rows_d   = rows_q;
        delay_d  = delay_q;
        issue_d  = issue_q;
        comp_d   = comp_q;
        mode_d   = mode_q;
        err_d    = err_q;
        accept_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept_s = 1'b1;
                    base_d   = cmd_base_addr;
                    rows_d   = cmd_rows;
                    delay_d  = cmd_start_delay;
                    mode_d   = cmd_mode;
                    issue_d  = '0;
                    if (cmd_rows == '0) begin
                        state_d = DONE;
                    end else if (cmd_start_delay == '0) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Entered with delay_q == D; leaves after exactly D cycles.
                if (delay_q <= ROWS_WIDTH'(1)) begin
                    state_d = ISSUE;
                end else begin
                    delay_d = delay_q - ROWS_WIDTH'(1);
                end
            end
            ISSUE: begin
                issue_d = issue_q + ROWS_WIDTH'(1);
                if (issue_q == rows_q - ROWS_WIDTH'(1)) begin
                    state_d = DRAIN;
                end else begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if ((comp_q == rows_q) && !pipe_busy_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completed output rows, saturating at the tile height.
        if (accept_s) begin
            comp_d = '0;
        end else if ((state_q != IDLE) && vpu_valid_in && (comp_q != rows_q)) begin
            comp_d = comp_q + ROWS_WIDTH'(1);
        end else begin
            comp_d = comp_q;
        end

        // A psum with no bias beside it is a sticky, non-blocking error.
        if (accept_s) begin
            err_d = 1'b0;
        end else if ((state_q != IDLE) && (|(vpu_sys_valid_in & ~vpu_bias_valid_out))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // FSM state, latched command and counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            rows_q  <= '0;
            delay_q <= '0;
            issue_q <= '0;
            comp_q  <= '0;
            mode_q  <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rows_q  <= rows_d;
            delay_q <= delay_d;
            issue_q <= issue_d;
            comp_q  <= comp_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    // Row token delayed by the buffer read latency (bypass tiles still generate it).
    always_ff @(posedge clk) begin
        if (!rst) begin
            tok_q <= '0;
        end else begin
            tok_q[0] <= issue_s;
            for (int k = 1; k < BIAS_RD_LATENCY; k++) begin
                tok_q[k] <= tok_q[k-1];
            end
        end
    end

    // Registered control outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            vpu_mode_q  <= 3'b000;
        end else begin
            cmd_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            rd_en_q     <= (state_d == ISSUE) && mode_d[VPU_MODE_BIAS_EN_BIT];
            rd_addr_q   <= (state_d == ISSUE) ? (base_d + ADDR_WIDTH'(issue_d)) : '0;
            vpu_mode_q  <= (state_d != IDLE) ? mode_d : 3'b000;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign bias_rd_en   = rd_en_q;
    assign bias_rd_addr = rd_addr_q;
    assign vpu_mode     = vpu_mode_q;
    assign err_misalign = err_q;

    // Lane j: one register stage for the buffer output plus j stages of skew.
    for (genvar j = 0; j < VPU_WIDTH; j++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_data_s;

        assign lane_data_s = (tok_s && bias_en_s) ? bias_rd_data[j*DATA_WIDTH +: DATA_WIDTH]
                                                  : '0;

        vpu_skew_line #(
            .DEPTH      (j + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_skew (
            .clk         (clk),
            .rst         (rst),
            .data_i      (lane_data_s),
            .valid_i     (tok_s),
            .data_o      (vpu_bias_data_out[j*DATA_WIDTH +: DATA_WIDTH]),
            .valid_o     (vpu_bias_valid_out[j]),
            .any_valid_o (lane_busy_s[j])
        );
    end

endmodule

// File: tb/tb_vpu_bias_sched.sv
// Directed bench for vpu_bias_sched with VPU_WIDTH=4.
module tb_vpu_bias_sched;

    localparam int VW = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_base_addr;
    logic [RW-1:0]    cmd_rows;
    logic [RW-1:0]    cmd_start_delay;
    logic [2:0]       cmd_mode;
    logic             bias_rd_en;
    logic [AW-1:0]    bias_rd_addr;
    logic [DW*VW-1:0] bias_rd_data;
    logic [2:0]       vpu_mode;
    logic [DW*VW-1:0] vpu_bias_data_out;
    logic [VW-1:0]    vpu_bias_valid_out;
    logic [VW-1:0]    vpu_sys_valid_in;
    logic             vpu_valid_in;
    logic             busy;
    logic             done;
    logic             err_misalign;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       vv;
        logic [3:0] sys;
        logic       rd;
        logic [7:0] addr;
        logic [3:0] vld;
        logic       dn;
        logic       rdy;
        logic       bsy;
        logic [2:0] md;
    } vec_t;

    vec_t tbl [15];

    always #5 clk = ~clk;

    vpu_bias_sched #(
        .VPU_WIDTH(VW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROWS_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_addr(cmd_base_addr), .cmd_rows(cmd_rows),
        .cmd_start_delay(cmd_start_delay), .cmd_mode(cmd_mode),
        .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
        .vpu_mode(vpu_mode), .vpu_bias_data_out(vpu_bias_data_out),
        .vpu_bias_valid_out(vpu_bias_valid_out), .vpu_sys_valid_in(vpu_sys_valid_in),
        .vpu_valid_in(vpu_valid_in), .busy(busy), .done(done), .err_misalign(err_misalign)
    );

    // Bias row pattern: element j of the row stored at address a.
    function automatic logic [31:0] pat(input logic [7:0] a, input int j);
        logic [7:0] jj;
        jj = 8'(j);
        return {a, jj, 8'hC3, ~a};
    endfunction

    function automatic logic [31:0] lane_out(input int j);
        return vpu_bias_data_out[j*DW +: DW];
    endfunction

    // Bias buffer model: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        for (int j = 0; j < VW; j++) begin
            bias_rd_data[j*DW +: DW] <= bias_rd_en ? pat(bias_rd_addr, j) : 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " rd_en"}, 32'(bias_rd_en), 32'd0);
        chk({tag, " valid"}, 32'(vpu_bias_valid_out), 32'd0);
        chk({tag, " mode"}, 32'(vpu_mode), 32'd0);
        for (int j = 0; j < VW; j++) chk($sformatf("%s data%0d", tag, j), lane_out(j), 32'd0);
    endtask

    function automatic vec_t mk(input logic vv, input logic [3:0] sys, input logic rd,
                                input logic [7:0] addr, input logic [3:0] vld, input logic dn,
                                input logic rdy, input logic bsy, input logic [2:0] md);
        vec_t v;
        v.vv = vv; v.sys = sys; v.rd = rd; v.addr = addr; v.vld = vld;
        v.dn = dn; v.rdy = rdy; v.bsy = bsy; v.md = md;
        return v;
    endfunction

    initial begin
        logic [31:0] ed;
        logic [7:0]  ea;
        logic [3:0]  em;

        // Bias add: base 0x10, M=3, D=2, mode 5; reads at k=3..5, lane j row i at 5+i+j.
        tbl[0]  = mk(1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0);
        tbl[1]  = mk(1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 3'd5);
        tbl[2]  = mk(1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 3'd5);
        tbl[3]  = mk(1'b0, 4'h0, 1'b1, 8'h10, 4'h0, 1'b0, 1'b0, 1'b1, 3'd5);
        tbl[4]  = mk(1'b0, 4'h0, 1'b1, 8'h11, 4'h0, 1'b0, 1'b0, 1'b1, 3'd5);
        tbl[5]  = mk(1'b0, 4'h1, 1'b1, 8'h12, 4'h1, 1'b0, 1'b0, 1'b1, 3'd5);
        tbl[6]  = mk(1'b0, 4'h3, 1'b0, 8'h00, 4'h3, 1'b0, 1'b0, 1'b1, 3'd5);
        tbl[7]  = mk(1'b0, 4'h7, 1'b0, 8'h00, 4'h7, 1'b0, 1'b0, 1'b1, 3'd5);
        tbl[8]  = mk(1'b0, 4'hE, 1'b0, 8'h00, 4'hE, 1'b0, 1'b0, 1'b1, 3'd5);
        tbl[9]  = mk(1'b1, 4'hC, 1'b0, 8'h00, 4'hC, 1'b0, 1'b0, 1'b1, 3'd5);
        tbl[10] = mk(1'b1, 4'h8, 1'b0, 8'h00, 4'h8, 1'b0, 1'b0, 1'b1, 3'd5);
        tbl[11] = mk(1'b1, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 3'd5);
        tbl[12] = mk(1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 3'd5);
        tbl[13] = mk(1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 3'd5);
        tbl[14] = mk(1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0);

        rst = 1'b0; cmd_valid = 1'b0; cmd_base_addr = 8'h00; cmd_rows = 8'd0;
        cmd_start_delay = 8'd0; cmd_mode = 3'd0; vpu_sys_valid_in = 4'h0; vpu_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        chk("reset err", 32'(err_misalign), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven bias-add tile.
        cmd_base_addr = 8'h10; cmd_rows = 8'd3; cmd_start_delay = 8'd2; cmd_mode = 3'b101;
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("add k%0d rd_en", k), 32'(bias_rd_en), 32'(tbl[k].rd));
            if (tbl[k].rd) chk($sformatf("add k%0d addr", k), 32'(bias_rd_addr), 32'(tbl[k].addr));
            chk($sformatf("add k%0d valid", k), 32'(vpu_bias_valid_out), 32'(tbl[k].vld));
            chk($sformatf("add k%0d done", k), 32'(done), 32'(tbl[k].dn));
            chk($sformatf("add k%0d ready", k), 32'(cmd_ready), 32'(tbl[k].rdy));
            chk($sformatf("add k%0d busy", k), 32'(busy), 32'(tbl[k].bsy));
            chk($sformatf("add k%0d mode", k), 32'(vpu_mode), 32'(tbl[k].md));
            chk($sformatf("add k%0d err", k), 32'(err_misalign), 32'd0);
            for (int j = 0; j < VW; j++) begin
                ed = tbl[k].vld[j] ? pat(8'h10 + 8'(k - 5 - j), j) : 32'd0;
                chk($sformatf("add k%0d data%0d", k, j), lane_out(j), ed);
            end
            cmd_valid = (k == 0); vpu_valid_in = tbl[k].vv; vpu_sys_valid_in = tbl[k].sys;
            @(negedge clk);
        end
        cmd_valid = 1'b0; vpu_valid_in = 1'b0; vpu_sys_valid_in = 4'h0;

        // Bypass: M=2, D=0, mode 6; no reads, zero data, valid at 3+j and 4+j, done at 9.
        cmd_base_addr = 8'h40; cmd_rows = 8'd2; cmd_start_delay = 8'd0; cmd_mode = 3'b110;
        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < VW; j++) em[j] = (k == 3 + j) || (k == 4 + j);
            chk($sformatf("byp k%0d rd_en", k), 32'(bias_rd_en), 32'd0);
            chk($sformatf("byp k%0d valid", k), 32'(vpu_bias_valid_out), 32'(em));
            chk($sformatf("byp k%0d done", k), 32'(done), 32'(k == 9));
            chk($sformatf("byp k%0d mode", k), 32'(vpu_mode), (k >= 1 && k <= 9) ? 32'd6 : 32'd0);
            for (int j = 0; j < VW; j++) chk($sformatf("byp k%0d data%0d", k, j), lane_out(j), 32'd0);
            cmd_valid = (k == 0); vpu_valid_in = (k == 4) || (k == 5);
            @(negedge clk);
        end
        cmd_valid = 1'b0; vpu_valid_in = 1'b0;

        // Empty tile: done at k=1, ready again at k=2, no reads or valids.
        cmd_base_addr = 8'h77; cmd_rows = 8'd0; cmd_start_delay = 8'd5; cmd_mode = 3'b001;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("m0 k%0d rd_en", k), 32'(bias_rd_en), 32'd0);
            chk($sformatf("m0 k%0d valid", k), 32'(vpu_bias_valid_out), 32'd0);
            chk($sformatf("m0 k%0d done", k), 32'(done), 32'(k == 1));
            chk($sformatf("m0 k%0d ready", k), 32'(cmd_ready), 32'(k != 1));
            chk($sformatf("m0 k%0d busy", k), 32'(busy), 32'(k == 1));
            cmd_valid = (k == 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;

        // Address wrap: base 0xFE, M=4; reads FE,FF,00,01 at k=1..4, done at 11.
        cmd_base_addr = 8'hFE; cmd_rows = 8'd4; cmd_start_delay = 8'd0; cmd_mode = 3'b001;
        for (int k = 0; k < 13; k++) begin
            chk($sformatf("wrap k%0d rd_en", k), 32'(bias_rd_en), 32'(k >= 1 && k <= 4));
            ea = 8'hFE + 8'(k - 1);
            if (k >= 1 && k <= 4) chk($sformatf("wrap k%0d addr", k), 32'(bias_rd_addr), 32'(ea));
            chk($sformatf("wrap k%0d lane0 valid", k), 32'(vpu_bias_valid_out[0]), 32'(k >= 3 && k <= 6));
            ea = 8'hFE + 8'(k - 3);
            ed = (k >= 3 && k <= 6) ? pat(ea, 0) : 32'd0;
            chk($sformatf("wrap k%0d lane0 data", k), lane_out(0), ed);
            chk($sformatf("wrap k%0d done", k), 32'(done), 32'(k == 11));
            cmd_valid = (k == 0); vpu_valid_in = (k >= 5 && k <= 8);
            @(negedge clk);
        end
        cmd_valid = 1'b0; vpu_valid_in = 1'b0;

        // Misalign: psum on lane 2 one cycle before its bias (k=4) -> sticky err from k=5.
        cmd_base_addr = 8'h20; cmd_rows = 8'd2; cmd_start_delay = 8'd0; cmd_mode = 3'b001;
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("mis k%0d err", k), 32'(err_misalign), 32'(k >= 5));
            chk($sformatf("mis k%0d lane2 valid", k), 32'(vpu_bias_valid_out[2]), 32'(k == 5 || k == 6));
            chk($sformatf("mis k%0d done", k), 32'(done), 32'(k == 9));
            cmd_valid = (k == 0); vpu_valid_in = (k == 5) || (k == 6);
            vpu_sys_valid_in = (k == 4) ? 4'b0100 : 4'b0000;
            @(negedge clk);
        end
        cmd_valid = 1'b0; vpu_valid_in = 1'b0; vpu_sys_valid_in = 4'h0;

        // Reset mid-ISSUE at row 1 of 4; the accept also clears the held error.
        cmd_base_addr = 8'h30; cmd_rows = 8'd4; cmd_start_delay = 8'd0; cmd_mode = 3'b001;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("rst k%0d err", k), 32'(err_misalign), 32'(k == 0));
            chk($sformatf("rst k%0d rd_en", k), 32'(bias_rd_en), 32'(k == 1 || k == 2));
            if (k == 1 || k == 2) chk($sformatf("rst k%0d addr", k), 32'(bias_rd_addr), 32'h30 + 32'(k - 1));
            if (k >= 3) check_idle($sformatf("rst k%0d", k));
            cmd_valid = (k == 0);
            rst = (k == 2) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0; rst = 1'b1;

        // Clean tile after the abort: M=1, D=1, base 0x50; read at k=2, done at 9.
        cmd_base_addr = 8'h50; cmd_rows = 8'd1; cmd_start_delay = 8'd1; cmd_mode = 3'b001;
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("post k%0d rd_en", k), 32'(bias_rd_en), 32'(k == 2));
            if (k == 2) chk("post addr", 32'(bias_rd_addr), 32'h50);
            chk($sformatf("post k%0d lane0 valid", k), 32'(vpu_bias_valid_out[0]), 32'(k == 4));
            chk($sformatf("post k%0d lane0 data", k), lane_out(0), (k == 4) ? pat(8'h50, 0) : 32'd0);
            chk($sformatf("post k%0d lane3 valid", k), 32'(vpu_bias_valid_out[3]), 32'(k == 7));
            chk($sformatf("post k%0d lane3 data", k), lane_out(3), (k == 7) ? pat(8'h50, 3) : 32'd0);
            chk($sformatf("post k%0d done", k), 32'(done), 32'(k == 9));
            chk($sformatf("post k%0d err", k), 32'(err_misalign), 32'd0);
            cmd_valid = (k == 0); vpu_valid_in = (k == 4);
            @(negedge clk);
        end
        cmd_valid = 1'b0; vpu_valid_in = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vpu_bias_sched.md
Name: vpu_bias_sched

Overview:
- Sequences the bias (C-matrix) path of the VPU for one D = E + C tile.
- Accepts a tile command, reads one C row per cycle from the bias buffer, and skews each row across lanes so lane j's bias meets the systolic array's psum for lane j.
- Counts completed VPU output rows, pulses done, and flags any cycle where a lane's psum arrives without bias.

Parameters:
VPU_WIDTH, 16, number of lanes (columns)
DATA_WIDTH, 32, bias element width (signed)
ADDR_WIDTH, 8, bias buffer row-address width
ROWS_WIDTH, 8, width of row count and start delay

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
cmd_valid  in  1  tile command offered
cmd_ready  out  1  scheduler idle, command accepted when cmd_valid&&cmd_ready
cmd_base_addr  in  ADDR_WIDTH  bias buffer address of row 0
cmd_rows  in  ROWS_WIDTH  number of rows M
cmd_start_delay  in  ROWS_WIDTH  wait D cycles between accept and first read
cmd_mode  in  3  VPU mode; bit0=1 bias add, bit0=0 bypass (zero bias)
bias_rd_en  out  1  bias buffer read strobe
bias_rd_addr  out  ADDR_WIDTH  row address
bias_rd_data  in  DATA_WIDTH x VPU_WIDTH  row data, valid 1 cycle after bias_rd_en
vpu_mode  out  3  latched cmd_mode while busy, else 0
vpu_bias_data_out  out  DATA_WIDTH x VPU_WIDTH  skewed bias to VPU
vpu_bias_valid_out  out  1 x VPU_WIDTH  skewed bias valid to VPU
vpu_sys_valid_in  in  1 x VPU_WIDTH  psum valid (monitor only)
vpu_valid_in  in  1  VPU output valid of lane VPU_WIDTH-1 (row-completion tick)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at tile completion
err_misalign  out  1  sticky alignment error

Behaviour:
- Reset (rst==0 at posedge): state IDLE; all outputs 0 except cmd_ready=1; skew pipes, counters, and err cleared. Reset mid-tile aborts with no done pulse.
- FSM states: IDLE, WAIT, ISSUE, DRAIN, DONE.
- IDLE: cmd_ready=1. On accept at cycle T:
  - latch base, M, D, and mode; clear err_misalign and row counters.
  - next state: M==0 -> DONE; D==0 -> ISSUE; otherwise WAIT.
- WAIT: delay counter runs for exactly D cycles, then ISSUE. First read occurs at T+1+D.
- ISSUE:
  - bias_rd_en=1 for exactly M consecutive cycles; row i address = base+i mod 2^ADDR_WIDTH (wraps, no error).
  - After the last read, go to DRAIN.
  - Bypass mode (bit0=0): bias_rd_en stays 0, but the same internal valid token is generated and the data lanes carry 0.
- Skew timing: if row i is read at cycle R_i, lane j presents the row-i element with valid=1 at cycle R_i+2+j.
  - Lane 0 registers bias_rd_data once; lane j adds j further register stages.
  - Valid travels with data; data is 0 whenever valid is 0.
- Completion counter:
  - increments on every vpu_valid_in==1 cycle from accept onward, in any state except IDLE.
  - saturates at M.
- DRAIN: exit to DONE when completion count == M and no skew-pipe valid is set.
- DONE: done=1 for one cycle, busy still 1, then IDLE.
- err_misalign:
  - set in any non-IDLE cycle where vpu_sys_valid_in[j]=1 and vpu_bias_valid_out[j]=0, for any j.
  - sticky until the next accept or reset; never blocks progress.
- vpu_mode holds the latched mode in all non-IDLE states.
- Commands offered while busy are not accepted (cmd_ready=0); the requester holds cmd_valid.
- Total bias latency per row is 2+j cycles; throughput is one row per cycle.

Decomposition:
- Package vpu_pkg holds:
  - state enum vpu_sched_state_e {IDLE, WAIT, ISSUE, DRAIN, DONE}
  - constant VPU_MODE_BIAS_EN_BIT = 0
  - localparam BIAS_RD_LATENCY = 1
- Sub-module vpu_skew_line #(DEPTH, DATA_WIDTH): a registered data+valid delay line.
  - instantiated once per lane with DEPTH = j+1.
  - clears to 0 on reset.

Test Plan:
- Bias add, VPU_WIDTH=4, M=3, D=2, base=0x10, accept at T=0:
  - reads at T=3,4,5, addr 0x10/0x11/0x12.
  - lane 3 row 0 valid at T=8.
  - feed 3 vpu_valid_in ticks -> done at the cycle after the last skew valid clears or the 3rd tick, whichever is later.
- Bypass, mode=0, M=2, D=0: bias_rd_en never asserts; lane j data=0 with valid at T+3+j and T+4+j; done after 2 ticks.
- M=0: accept at T -> done=1 at T+1, cmd_ready=1 at T+2, no reads, no valids.
- Wrap, base=0xFE, M=4: addresses 0xFE, 0xFF, 0x00, 0x01 on consecutive cycles.
- Misalign: drive vpu_sys_valid_in[2]=1 one cycle before lane-2 bias valid -> err_misalign=1 and held; the next accept clears it.
- Reset mid-ISSUE at row 1 of 4: the next cycle has all valids 0, bias_rd_en=0, cmd_ready=1, no done pulse; a new command runs cleanly.
